// File: rtl/hdr_mode_ctrl.sv
// Target-side HDR mode controller: hands the bus between the SDR and HDR-DDR engines
// and detects the HDR Exit / Restart patterns. Optional pending-state timeout: HDR_EXIT_TIMEOUT_EN.
module hdr_mode_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_W          = 11
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    input  logic       i_enthdr_valid,
    input  logic [2:0] i_enthdr_mode,
    output logic       o_sdr_en,
    output logic       o_ddr_en,
    output logic [1:0] o_mode,
    output logic       o_exit_det,
    output logic       o_restart_det,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        ST_SDR       = 3'd0,
        ST_HDR_DDR   = 3'd1,
        ST_HDR_IGN   = 3'd2,
        ST_EXIT_PEND = 3'd3,
        ST_EXIT_STOP = 3'd4,
        ST_RST_PEND  = 3'd5
    } state_e;

    if ((2 ** TMO_W) <= TIMEOUT_CYCLES) begin : g_tmo_w_check
        $error("hdr_mode_ctrl: TMO_W too narrow for TIMEOUT_CYCLES");
    end

    state_e     state_q, state_d;
    logic       ret_ign_q, ret_ign_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       scl_q, sda_q;
    logic       exit_d, restart_d;
    logic       sdr_en_d, ddr_en_d;
    logic [1:0] mode_d;
    state_e     ret_state;

    logic scl_edge, scl_rise, scl_fall, sda_rise, sda_fall;

    assign scl_edge  = i_scl ^ scl_q;
    assign scl_rise  = i_scl & ~scl_q;
    assign scl_fall  = ~i_scl & scl_q;
    assign sda_rise  = i_sda & ~sda_q;
    assign sda_fall  = ~i_sda & sda_q;
    assign ret_state = ret_ign_q ? ST_HDR_IGN : ST_HDR_DDR;

`ifdef HDR_EXIT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pend_q;
    assign pend_q = (state_q == ST_EXIT_PEND) || (state_q == ST_EXIT_STOP) ||
                    (state_q == ST_RST_PEND);
`endif

    always_comb begin
        state_d   = state_q;
        ret_ign_d = ret_ign_q;
        fcnt_d    = fcnt_q;
        exit_d    = 1'b0;
        restart_d = 1'b0;
        case (state_q)
            ST_SDR: begin
                fcnt_d = 3'd0;
                if (i_enthdr_valid) begin
                    ret_ign_d = (i_enthdr_mode != 3'd0);
                    state_d   = (i_enthdr_mode == 3'd0) ? ST_HDR_DDR : ST_HDR_IGN;
                end
            end
            ST_HDR_DDR, ST_HDR_IGN: begin
                // SCL edges win over a same-cycle SDA edge, so that SDA edge is never counted
                if (scl_edge) begin
                    fcnt_d = 3'd0;
                    if (scl_rise && (fcnt_q == 3'd2) && i_sda) begin
                        state_d = ST_RST_PEND;
                    end
                end else if (sda_fall && !i_scl) begin
                    fcnt_d = (fcnt_q >= 3'd4) ? 3'd4 : fcnt_q + 3'd1;
                    if (fcnt_q >= 3'd3) begin
                        state_d = ST_EXIT_PEND;
                    end
                end
            end
            ST_EXIT_PEND: begin
                fcnt_d = 3'd0;
                if (scl_rise) begin
                    state_d = ST_EXIT_STOP;
                end
            end
            ST_EXIT_STOP: begin
                fcnt_d = 3'd0;
                if (scl_fall) begin
                    state_d = ret_state;
                end else if (sda_rise) begin
                    state_d = ST_SDR;
                    exit_d  = 1'b1;
                end
            end
            ST_RST_PEND: begin
                fcnt_d = 3'd0;
                if (scl_fall) begin
                    state_d = ret_state;
                end else if (sda_fall) begin
                    state_d   = ret_state;
                    restart_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_SDR;
                fcnt_d  = 3'd0;
            end
        endcase

`ifdef HDR_EXIT_TIMEOUT_EN
        tmo_d = '0;
        if (pend_q && (state_d == state_q)) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ret_state;
                fcnt_d  = 3'd0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif

        // Outputs are decoded from the next state so they register alongside it
        sdr_en_d = (state_d == ST_SDR);
        ddr_en_d = (state_d != ST_SDR) && !ret_ign_d && !restart_d;
        if (state_d == ST_SDR) begin
            mode_d = 2'd0;
        end else begin
            mode_d = ret_ign_d ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q       <= ST_SDR;
            ret_ign_q     <= 1'b0;
            fcnt_q        <= 3'd0;
            scl_q         <= 1'b1;
            sda_q         <= 1'b1;
            o_sdr_en      <= 1'b1;
            o_ddr_en      <= 1'b0;
            o_mode        <= 2'd0;
            o_exit_det    <= 1'b0;
            o_restart_det <= 1'b0;
`ifdef HDR_EXIT_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ret_ign_q     <= ret_ign_d;
            fcnt_q        <= fcnt_d;
            scl_q         <= i_scl;
            sda_q         <= i_sda;
            o_sdr_en      <= sdr_en_d;
            o_ddr_en      <= ddr_en_d;
            o_mode        <= mode_d;
            o_exit_det    <= exit_d;
            o_restart_det <= restart_d;
`ifdef HDR_EXIT_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: doc/hdr_mode_ctrl.md
Name: hdr_mode_ctrl

Overview:
- Target-side HDR mode controller. It owns the hand-over between the SDR engine and the HDR-DDR engine.
- Enters HDR on an ENTHDR CCC reported by the SDR/CCC decoder.
- While in HDR, monitors the bus for the HDR Exit pattern and the HDR Restart pattern.
- Drives the engine enables and reports exit and restart as single-cycle pulses.

Parameters:
- TIMEOUT_CYCLES, 1024, max i_sys_clk cycles allowed in any pattern-pending state before abort (used only with the optional feature).
- TMO_W, 11, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  asynchronous reset, active-low.
- i_scl  in  1  SCL, already synchronized to i_sys_clk.
- i_sda  in  1  SDA, already synchronized to i_sys_clk.
- i_enthdr_valid  in  1  one-cycle pulse: ENTHDRx CCC fully received and ACKed.
- i_enthdr_mode  in  3  HDR mode index x of ENTHDRx; 0 = HDR-DDR.
- o_sdr_en  out  1  SDR engine enable.
- o_ddr_en  out  1  HDR-DDR engine enable.
- o_mode  out  2  0 = SDR, 1 = HDR-DDR, 2 = HDR-ignore (unsupported mode); 3 never driven.
- o_exit_det  out  1  one-cycle pulse: HDR Exit plus STOP completed.
- o_restart_det  out  1  one-cycle pulse: HDR Restart completed.

Behaviour:
- Reset: all state asynchronously cleared.
  - o_sdr_en = 1; o_ddr_en = 0; o_mode = 0; o_exit_det = 0; o_restart_det = 0.
  - FSM = SDR; falling-edge count = 0; scl_q = 1, sda_q = 1.
- Edge detection:
  - scl_q/sda_q register i_scl/i_sda every cycle.
  - Edge = current input differs from the _q value.
  - An edge is acted on at the first clock edge that samples the new level.
- SDA fall counter (sda_fcnt, 3 bits, saturating at 4):
  - Cleared on any SCL edge.
  - Increments on each SDA falling edge while i_scl = 0.
  - Active only in HDR_DDR / HDR_IGN.
- All outputs are registered.
- FSM states and transitions:
  - SDR
    - i_enthdr_valid with mode 0 -> HDR_DDR.
    - i_enthdr_valid with mode != 0 -> HDR_IGN.
    - i_enthdr_valid = 0 -> stay.
  - HDR_DDR / HDR_IGN (the FSM remembers which one, as the return state)
    - sda_fcnt reaches 4 -> EXIT_PEND.
    - SCL rising edge with sda_fcnt == 2 and i_sda = 1 -> RST_PEND.
    - Any other SCL edge: counter clears, state unchanged.
  - EXIT_PEND
    - Further SDA toggles are ignored.
    - SCL rising edge -> EXIT_STOP.
  - EXIT_STOP (SCL high)
    - SDA rising edge -> SDR, o_exit_det = 1 for one cycle.
    - SCL falling edge -> return state, count cleared.
  - RST_PEND (SCL high, SDA high)
    - SDA falling edge -> return state, o_restart_det = 1 for one cycle.
    - SCL falling edge -> return state, no pulse.
- Output decode:
  - o_sdr_en = 1 only in SDR.
  - o_ddr_en = 1 in HDR_DDR, and in pending states whose return state is HDR_DDR.
  - o_ddr_en is forced 0 for exactly the cycle o_restart_det is high, so the DDR engine re-initializes.
  - o_mode reflects the SDR / return state; it is unchanged during pending states.
- Exit completion: o_sdr_en rises and o_ddr_en falls in the same cycle o_exit_det is high.
- Boundary conditions:
  - i_enthdr_valid outside SDR is ignored.
  - A simultaneous SCL and SDA edge in the same cycle: the SCL edge takes priority, counter clears, and the SDA edge is not counted.
  - A restart in HDR_IGN pulses o_restart_det and stays in HDR_IGN, with o_ddr_en held 0.
  - Reset asserted mid-pattern returns to SDR immediately.

Optional Feature:
- Macro: HDR_EXIT_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter runs in EXIT_PEND, EXIT_STOP and RST_PEND; it is cleared on entering any of them.
  - On reaching TIMEOUT_CYCLES the FSM returns to the return state, the count is cleared, and no pulse is issued.
- Undefined: no counter; the pending states wait indefinitely.

Test Plan:
1. i_enthdr_valid with mode 0 -> next cycle o_mode = 1, o_ddr_en = 1, o_sdr_en = 0. Then with SCL low, 4 SDA falls, SCL rises, SDA rises -> o_exit_det high one cycle, o_mode = 0, o_sdr_en = 1.
2. In HDR_DDR, SCL low, 2 SDA falls, SDA high, SCL rises, SDA falls -> o_restart_det one cycle, o_ddr_en = 0 that cycle then 1, o_mode stays 1.
3. Normal DDR traffic (one SDA change per SCL half-period for 40 half-periods) -> no pulses, o_mode = 1 throughout.
4. i_enthdr_valid with mode 3 -> o_mode = 2, o_ddr_en = 0. Exit pattern -> o_exit_det, back to SDR.
5. Exit pattern reaches EXIT_STOP, then SCL falls before SDA rises -> no pulse, o_mode = 1. Also: i_sys_rst pulsed in EXIT_PEND -> all outputs at reset values.
6. With HDR_EXIT_TIMEOUT_EN and TIMEOUT_CYCLES = 16: hold in EXIT_PEND for 20 cycles -> returns to HDR_DDR at cycle 16, no o_exit_det.
